// File: rtl/unsigned_mul_ha_pipe.sv
// Pipelined unsigned WIDTHxWIDTH multiplier: half-adder row-pair arrays with optional
// per-beat OR-sum approximation in low columns, exact deficit output and inexact counter.
module unsigned_mul_ha_pipe #(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 4,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_y,
  input  logic               in_approx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [2*WIDTH-1:0] out_deficit,
  output logic [CNT_W-1:0]   inexact_cnt,
  input  logic               cnt_clr
);

  localparam int PAIRS = WIDTH / 2;
  localparam int PW    = 2 * WIDTH;

  logic             s1_valid, s2_valid;
  logic             ld1, ld2, ld3;
  logic [WIDTH-1:0] s1_x, s1_y;
  logic             s1_approx;

  // Array outputs per row pair; t[WIDTH] is always zero and is not stored.
  logic [WIDTH-1:0] t_c  [PAIRS];
  logic [WIDTH-1:0] b_c  [PAIRS];
  logic [PW-1:0]    d_c  [PAIRS];
  logic [WIDTH-1:0] s2_t [PAIRS];
  logic [WIDTH-1:0] s2_b [PAIRS];
  logic [PW-1:0]    s2_d [PAIRS];
  logic [PW-1:0]    p_sum, d_sum;

  // A stage accepts when it is empty or its successor accepts this cycle.
  assign ld3      = !out_valid || out_ready;
  assign ld2      = !s2_valid || ld3;
  assign ld1      = !s1_valid || ld2;
  assign in_ready = ld1;

  // NOTE: state registers use non-blocking assignments so every stage samples the
  // pre-edge value of its predecessor, whatever the textual order of the statements.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (ld1) s1_valid  <= in_valid;
      if (ld2) s2_valid  <= s1_valid;
      if (ld3) out_valid <= s2_valid;
    end
  end

  // NOTE: S1/S2 payload is qualified by the valid bits, so it carries no reset;
  // only the externally visible S3 registers are cleared.
  always_ff @(posedge clk) begin
    if (ld1 && in_valid) begin
      s1_x      <= in_x;
      s1_y      <= in_y;
      s1_approx <= in_approx;
    end
  end

  // NOTE: every combinational output gets a default before the loops, so no path
  // leaves a bit unassigned and no latch is inferred.
  always_comb begin
    logic a_bit, b_bit;
    a_bit = 1'b0;
    b_bit = 1'b0;
    for (int k = 0; k < PAIRS; k++) begin
      t_c[k] = '0;
      b_c[k] = '0;
      d_c[k] = '0;
      t_c[k][0] = s1_y[0] & s1_x[2*k];
      for (int j = 1; j < WIDTH; j++) begin
        a_bit = s1_y[j]   & s1_x[2*k];
        b_bit = s1_y[j-1] & s1_x[2*k+1];
        if (s1_approx && (2*k + j < APPROX_COLS)) begin
          t_c[k][j] = a_bit | b_bit;
          d_c[k]    = d_c[k] | (PW'(a_bit & b_bit) << (2*k + j));
        end else begin
          t_c[k][j]   = a_bit ^ b_bit;
          b_c[k][j-1] = a_bit & b_bit;
        end
      end
      b_c[k][WIDTH-1] = s1_y[WIDTH-1] & s1_x[2*k+1];
    end
  end

  always_ff @(posedge clk) begin
    if (ld2 && s1_valid) begin
      s2_t <= t_c;
      s2_b <= b_c;
      s2_d <= d_c;
    end
  end

  // Carries of columns 1..WIDTH-1 weigh 2^(i+2); the pass-through top bit of B weighs 2^WIDTH.
  always_comb begin
    p_sum = '0;
    d_sum = '0;
    for (int k = 0; k < PAIRS; k++) begin
      p_sum = p_sum + ((PW'(s2_t[k])
                      + (PW'(s2_b[k][WIDTH-2:0]) << 2)
                      + (PW'(s2_b[k][WIDTH-1]) << WIDTH)) << (2*k));
      d_sum = d_sum + s2_d[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_p       <= '0;
      out_deficit <= '0;
    end else if (ld3 && s2_valid) begin
      out_p       <= p_sum;
      out_deficit <= d_sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inexact_cnt <= '0;
    end else if (cnt_clr) begin
      inexact_cnt <= '0;
    end else if (out_valid && out_ready && (out_deficit != '0) && (inexact_cnt != '1)) begin
      inexact_cnt <= inexact_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_unsigned_mul_ha_pipe.sv
// Scoreboard bench for unsigned_mul_ha_pipe: an 8-bit/4-column instance under directed and
// random traffic, plus a 6-bit/7-column instance under fully random valid/ready traffic.
module tb_unsigned_mul_ha_pipe;

  typedef struct {
    int unsigned p;
    int unsigned d;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- instance A: WIDTH=8, APPROX_COLS=4
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, in_approx = 1'b0;
  logic [7:0]  in_x = '0, in_y = '0;
  logic        out_valid, out_ready;
  logic [15:0] out_p, out_deficit, inexact_cnt;
  logic        cnt_clr = 1'b0;
  logic        ready_mode = 1'b0, ready_fixed = 1'b1, ready_rnd = 1'b1;

  assign out_ready = ready_mode ? ready_rnd : ready_fixed;

  unsigned_mul_ha_pipe #(.WIDTH(8), .APPROX_COLS(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_approx(in_approx),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_deficit(out_deficit),
    .inexact_cnt(inexact_cnt), .cnt_clr(cnt_clr)
  );

  // ---------------- instance B: WIDTH=6, APPROX_COLS=7
  logic        rst_b = 1'b1;
  logic        b_valid = 1'b0, b_in_ready, b_approx = 1'b0;
  logic [5:0]  b_x = '0, b_y = '0;
  logic        b_out_valid, b_out_ready = 1'b1;
  logic [11:0] b_p, b_deficit;
  logic [15:0] b_cnt;
  logic        b_done = 1'b0;

  unsigned_mul_ha_pipe #(.WIDTH(6), .APPROX_COLS(7), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst_b), .in_valid(b_valid), .in_ready(b_in_ready),
    .in_x(b_x), .in_y(b_y), .in_approx(b_approx),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_p(b_p), .out_deficit(b_deficit),
    .inexact_cnt(b_cnt), .cnt_clr(1'b0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: bound expired, got no event, expected one", name);
  endtask

  // Reference: an OR-sum cell whose two inputs are both 1 yields sum 1 instead of
  // (sum 0, carry 1), losing 2^c at column c. Everything else is exact.
  function automatic void model(input int w, input int cols, input int unsigned x,
                                input int unsigned y, input bit ap,
                                output int unsigned p, output int unsigned d);
    d = 0;
    if (ap)
      for (int k = 0; k < w / 2; k++)
        for (int j = 1; j < w; j++)
          if ((2*k + j < cols) && x[2*k] && x[2*k+1] && y[j] && y[j-1])
            d += 32'd1 << (2*k + j);
    p = x * y - d;
  endfunction

  // ---------------- scoreboard/monitor for A
  exp_t        q_a[$];
  int unsigned cnt_model = 0;
  bit          prev_stall = 1'b0;
  logic [15:0] hold_p, hold_d;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("inexact_cnt", inexact_cnt, cnt_model);
      if (prev_stall) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_p", out_p, hold_p);
        check("hold_deficit", out_deficit, hold_d);
      end
      prev_stall = out_valid && !out_ready;
      hold_p = out_p;
      hold_d = out_deficit;
      if (out_valid && out_ready) begin
        if (q_a.size() == 0) begin
          n_checks++;
          $display("FAIL a_unexpected_beat: got p=%0d with empty scoreboard, expected none", out_p);
        end else begin
          e = q_a.pop_front();
          check("a_p", out_p, e.p);
          check("a_deficit", out_deficit, e.d);
          if (cnt_clr) cnt_model = 0;
          else if (e.d != 0 && cnt_model != 32'hFFFF) cnt_model++;
        end
      end else if (cnt_clr) begin
        cnt_model = 0;
      end
      if (in_valid && in_ready) begin
        model(8, 4, in_x, in_y, in_approx, e.p, e.d);
        q_a.push_back(e);
      end
    end
  end

  // ---------------- scoreboard/monitor and random driver for B
  exp_t        q_b[$];
  int unsigned b_inexact = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_b) begin
      if (b_out_valid && b_out_ready) begin
        if (q_b.size() == 0) begin
          n_checks++;
          $display("FAIL b_unexpected_beat: got p=%0d with empty scoreboard, expected none", b_p);
        end else begin
          e = q_b.pop_front();
          check("b_p", b_p, e.p);
          check("b_deficit", b_deficit, e.d);
          if (e.d != 0) b_inexact++;
        end
      end
      if (b_valid && b_in_ready) begin
        model(6, 7, b_x, b_y, b_approx, e.p, e.d);
        q_b.push_back(e);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      b_valid     = $urandom_range(0, 3) != 0;
      b_x         = 6'($urandom_range(0, 63));
      b_y         = 6'($urandom_range(0, 63));
      b_approx    = 1'($urandom_range(0, 1));
      b_out_ready = $urandom_range(0, 2) != 0;
    end
    b_valid     = 1'b0;
    b_out_ready = 1'b1;
    repeat (20) @(posedge clk);
    b_done = 1'b1;
  end

  always @(posedge clk) begin
    #1 ready_rnd = $urandom_range(0, 2) != 0;
  end

  // ---------------- A stimulus helpers (all called just after a rising edge)
  task automatic send(input int unsigned x, input int unsigned y, input bit ap);
    int n = 0;
    in_valid  = 1'b1;
    in_x      = x[7:0];
    in_y      = y[7:0];
    in_approx = ap;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) fail_now("send_timeout");
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Empty pipe, out_ready held 1: result must show exactly three edges after acceptance.
  task automatic send_timed(input int unsigned x, input int unsigned y, input bit ap,
                            input int unsigned exp_p, input int unsigned exp_d);
    send(x, y, ap);
    @(negedge clk); check("lat_edge1", out_valid, 1'b0);
    @(negedge clk); check("lat_edge2", out_valid, 1'b0);
    @(negedge clk); check("lat_edge3", out_valid, 1'b1);
    check("dir_p", out_p, exp_p);
    check("dir_deficit", out_deficit, exp_d);
    @(posedge clk); #1;
  endtask

  task automatic drain_a();
    int n = 0;
    while ((q_a.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (q_a.size() != 0 || out_valid) fail_now("drain_a");
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_p", out_p, 16'd0);
    check("rst_out_deficit", out_deficit, 16'd0);
    check("rst_inexact_cnt", inexact_cnt, 16'd0);
    check("rst_in_ready", in_ready, 1'b1);

    // directed values
    send_timed(255, 255, 1'b0, 65025, 0);
    @(negedge clk); check("cnt_after_exact", inexact_cnt, 16'd0);
    @(posedge clk); #1;
    send_timed(3, 3, 1'b1, 7, 2);
    @(negedge clk); check("cnt_after_approx", inexact_cnt, 16'd1);
    @(posedge clk); #1;
    send_timed(255, 255, 1'b1, 65003, 22);

    // backpressure: three beats fill the pipe, the fourth must wait
    ready_fixed = 1'b0;
    send(1, 2, 1'b0);
    send(3, 7, 1'b1);
    send(5, 6, 1'b1);
    in_valid = 1'b1; in_x = 8'd7; in_y = 8'd8; in_approx = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready_low", in_ready, 1'b0);
    end
    @(posedge clk); #1;
    ready_fixed = 1'b1;
    send(7, 8, 1'b0);
    send(9, 10, 1'b1);
    drain_a();

    // random sweep with random gaps and random out_ready
    ready_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end else begin
        send($urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)));
      end
    end
    ready_mode = 1'b0;
    ready_fixed = 1'b1;
    drain_a();

    // reset mid-stream with two beats held in flight
    send(3, 3, 1'b1);
    drain_a();
    ready_fixed = 1'b0;
    send(3, 3, 1'b1);
    send(255, 255, 1'b1);
    rst = 1'b1;
    q_a.delete();
    cnt_model  = 0;
    prev_stall = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid, 1'b0);
    check("rst_mid_inexact_cnt", inexact_cnt, 16'd0);
    check("rst_mid_out_p", out_p, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    ready_fixed = 1'b1;
    check("post_rst_in_ready", in_ready, 1'b1);
    send_timed(6, 7, 1'b0, 42, 0);
    drain_a();

    // clear concurrent with a counting beat
    send(3, 3, 1'b1);
    drain_a();
    ready_fixed = 1'b0;
    send(255, 255, 1'b1);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) fail_now("clr_wait_valid");
    @(posedge clk); #1;
    cnt_clr     = 1'b1;
    ready_fixed = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    check("clr_priority", inexact_cnt, 16'd0);
    @(posedge clk); #1;
    drain_a();

    // wait for instance B
    n = 0;
    while (!b_done && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (!b_done) fail_now("b_done_timeout");
    check("b_drained", q_b.size(), 0);
    check("b_inexact_cnt", b_cnt, b_inexact);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
